// File: rtl/mealy_seq_detector_param.sv
// mealy_seq_detector_param: run-time loadable Mealy sequence detector with
// overlap control and a saturating match counter.
module mealy_seq_detector_param #(
    parameter int                 MAX_LEN = 8,
    parameter int                 LEN_W   = 4,
    parameter int                 CNT_W   = 8,
    parameter logic [MAX_LEN-1:0] PAT_RST = MAX_LEN'('h0B),
    parameter logic [LEN_W-1:0]   LEN_RST = LEN_W'(4)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic               i_x,
    input  logic               i_overlap,
    input  logic               i_pat_load,
    input  logic [MAX_LEN-1:0] i_pat_in,
    input  logic [LEN_W-1:0]   i_len_in,
    input  logic               i_clr_cnt,
    output logic               o_z,
    output logic [CNT_W-1:0]   o_match_cnt,
    output logic               o_cnt_sat
);
    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_MIN  = LEN_W'(2);

    logic [MAX_LEN-1:0] r_pat;
    logic [LEN_W-1:0]   r_len;
    // The oldest history bit can never take part in a compare, so only
    // MAX_LEN-1 bits are stored; the incoming bit completes the window.
    logic [MAX_LEN-2:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [CNT_W-1:0]   r_cnt;

    logic [MAX_LEN-1:0] w_win;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_hit;
    logic               w_full;
    logic               w_len_ok;
    logic [LEN_W-1:0]   w_fill_nxt;

    assign w_win = {r_hist, i_x};

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++)
            w_mask[i] = (i < int'(r_len));
    end

    assign w_hit      = (((w_win ^ r_pat) & w_mask) == '0);
    assign w_full     = (r_fill >= r_len - LEN_W'(1));
    assign o_z        = i_en & ~i_pat_load & w_full & w_hit;
    assign w_len_ok   = (i_len_in >= LEN_MIN) && (i_len_in <= LEN_MAX);
    assign w_fill_nxt = (o_z & ~i_overlap) ? '0 :
                        (r_fill == FILL_MAX) ? r_fill : r_fill + LEN_W'(1);
    assign o_cnt_sat   = &r_cnt;
    assign o_match_cnt = r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pat  <= PAT_RST;
            r_len  <= LEN_RST;
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_pat_load) begin
            if (w_len_ok) begin
                r_pat  <= i_pat_in;
                r_len  <= i_len_in;
                r_hist <= '0;
                r_fill <= '0;
            end
        end else if (i_en) begin
            r_hist <= w_win[MAX_LEN-2:0];
            r_fill <= w_fill_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_clr_cnt)
            r_cnt <= '0;
        else if (o_z && !o_cnt_sat)
            r_cnt <= r_cnt + CNT_W'(1);
    end
endmodule
